// File: rtl/popcount_unary_ser8_pkg.sv
// popcount_unary_ser8_pkg: shared sizes, FSM state codes and count saturation
// for the unary serialiser.
package popcount_unary_ser8_pkg;

   localparam int WIDTH = 8;                // bits emitted per accepted count
   localparam int CW    = 4;                // count width, 2^CW > WIDTH
   localparam int IDX_W = $clog2(WIDTH);    // bit index within a word

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // true when an offered count cannot be represented in WIDTH bits
   function automatic logic over_width(input logic [CW-1:0] c);
      return {1'b0, c} > (CW+1)'(WIDTH);
   endfunction

   // min(c, WIDTH), compared one bit wider so WIDTH itself never wraps
   function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] c);
      return over_width(c) ? CW'(WIDTH) : c;
   endfunction

endpackage

// File: rtl/popcount_unary_ser8_if.sv
// popcount_unary_ser8_if: count input channel, serial output channel and the
// sticky clamp flag. O_par only exists when POPCOUNT_UNARY_SER8_PAR_EN is defined.
interface popcount_unary_ser8_if;
   import popcount_unary_ser8_pkg::*;

   logic          I_valid;
   logic          I_ready;
   logic [CW-1:0] I;
   logic          O_valid;
   logic          O_ready;
   logic          O;
   logic          O_last;
   logic          clamp;
`ifdef POPCOUNT_UNARY_SER8_PAR_EN
   logic [WIDTH-1:0] O_par;

   modport slave  (input  I_valid, I, O_ready,
                   output I_ready, O_valid, O, O_last, clamp, O_par);
   modport master (output I_valid, I, O_ready,
                   input  I_ready, O_valid, O, O_last, clamp, O_par);
`else
   modport slave  (input  I_valid, I, O_ready,
                   output I_ready, O_valid, O, O_last, clamp);
   modport master (output I_valid, I, O_ready,
                   input  I_ready, O_valid, O, O_last, clamp);
`endif

endinterface

// File: rtl/popcount_unary_ser8_thermo.sv
// popcount_thermo_dec: count -> thermometer mask, mask[i] = (i < cnt).
module popcount_thermo_dec #(
   parameter int W = 8,
   parameter int C = 4
) (
   input  logic [C-1:0] cnt,
   output logic [W-1:0] mask
);

   // one comparator per bit lane, widened so cnt == W still sets every bit
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign mask[i] = ({1'b0, cnt} > (C+1)'(i));
   end

endmodule

// File: rtl/popcount_unary_ser8.sv
// popcount_unary_ser8: accepts a count and serialises its WIDTH-bit thermometer
// word LSB first, one bit per O handshake. Optional feature macro
// POPCOUNT_UNARY_SER8_PAR_EN adds the parallel word O_par.
module popcount_unary_ser8
   import popcount_unary_ser8_pkg::*;
(
   input logic                    CLK,
   input logic                    ASYNCRESETN,
   popcount_unary_ser8_if.slave   bus
);

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [IDX_W-1:0] idx;
   logic             clamp_q;
   logic [WIDTH-1:0] mask;
   logic             shifting;
   logic             accept;

   // mask only changes when cnt is reloaded, so it is stable for the whole word
   popcount_thermo_dec #(.W(WIDTH), .C(CW)) u_dec (
      .cnt  (cnt),
      .mask (mask)
   );

   assign shifting    = (state == ST_SHIFT);
   assign bus.O_valid = shifting;
   assign bus.O       = shifting && mask[idx];
   assign bus.O_last  = shifting && (idx == IDX_W'(WIDTH-1));
   assign bus.clamp   = clamp_q;
   // the only input-to-output path: a new count is taken as the last bit leaves
   assign bus.I_ready = !shifting || (bus.O_ready && bus.O_last);
   assign accept      = bus.I_valid && bus.I_ready;

`ifdef POPCOUNT_UNARY_SER8_PAR_EN
   // cnt is loaded only at accept, so its decode is the word registered at accept
   assign bus.O_par = mask;
`endif

   // FSM: load count on accept, step idx per taken bit, drop to IDLE after last
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state <= ST_IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else if (accept) begin
         state <= ST_SHIFT;
         cnt   <= sat_cnt(bus.I);
         idx   <= '0;
      end else if (shifting && bus.O_ready) begin
         if (bus.O_last) begin
            state <= ST_IDLE;
            idx   <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   // sticky overflow flag, cleared only by reset
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN)                      clamp_q <= 1'b0;
      else if (accept && over_width(bus.I))  clamp_q <= 1'b1;
   end

endmodule

// File: tb/tb_popcount_unary_ser8.sv
// tb_popcount_unary_ser8: scoreboard bench for the unary serialiser.
module tb_popcount_unary_ser8;
   import popcount_unary_ser8_pkg::*;

   logic CLK = 1'b0;
   logic ASYNCRESETN = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   logic [1:0] q[$];     // {bit, last} expected per serial transfer

   popcount_unary_ser8_if bus ();

   popcount_unary_ser8 dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .bus         (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // scoreboard: every transfer is checked against the oldest expected bit
   always @(negedge CLK) begin
      logic [1:0] e;
      if (ASYNCRESETN && bus.O_valid && bus.O_ready) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got O=%b O_last=%b, expected no transfer", bus.O, bus.O_last);
         end else begin
            e = q.pop_front();
            if ({bus.O, bus.O_last} !== e) begin
               fails++;
               $display("FAIL sb_bit: got O=%b O_last=%b, expected O=%b O_last=%b",
                        bus.O, bus.O_last, e[1], e[0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // offer count c, wait for acceptance, load the expected word; returns #1 after the accept edge
   task automatic send(input logic [CW-1:0] c, output int acc_cyc);
      int n;
      int k;
      bit ok;
      n = (int'(c) > WIDTH) ? WIDTH : int'(c);
      bus.I = c;
      bus.I_valid = 1'b1;
      ok = 0;
      acc_cyc = -1;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge CLK);
         if (bus.I_ready) begin
            for (k = 0; k < WIDTH; k++) q.push_back({(k < n) ? 1'b1 : 1'b0, (k == WIDTH-1) ? 1'b1 : 1'b0});
            ok = 1;
         end
         @(posedge CLK);
         if (ok) acc_cyc = cyc;
         #1;
      end
      bus.I_valid = 1'b0;
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL send_timeout: I_ready never seen for count %0d", c);
      end
   endtask

   task automatic drain();
      int t;
      for (t = 0; t < 200 && q.size() != 0; t++) @(posedge CLK);
      #1;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d bits still expected", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      bus.I_valid = 1'b0;
      bus.I = '0;
      bus.O_ready = 1'b1;
      ASYNCRESETN = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      tests++;
      if ({bus.I_ready, bus.O_valid, bus.O, bus.O_last, bus.clamp} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_outputs: got rdy/vld/O/last/clamp=%b, expected 10000",
                  {bus.I_ready, bus.O_valid, bus.O, bus.O_last, bus.clamp});
      end
`ifdef POPCOUNT_UNARY_SER8_PAR_EN
      tests++;
      if (bus.O_par !== '0) begin
         fails++;
         $display("FAIL reset_par: got %h, expected 00", bus.O_par);
      end
`endif
      ASYNCRESETN = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_basic();
      int a;
      bus.O_ready = 1'b1;
      send(4'd3, a);
      tests++;
      if ({bus.O_valid, bus.O, bus.O_last} !== 3'b110) begin
         fails++;
         $display("FAIL first_bit: got vld/O/last=%b, expected 110", {bus.O_valid, bus.O, bus.O_last});
      end
      drain();
      tests++;
      if (bus.clamp !== 1'b0 || bus.O_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_end: got clamp=%b O_valid=%b, expected 0 0", bus.clamp, bus.O_valid);
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      int a1;
      bus.O_ready = 1'b1;
      send(4'd0, a0);
      send(4'd8, a1);
      tests++;
      if (a1 - a0 != WIDTH) begin
         fails++;
         $display("FAIL b2b_gap: got %0d cycles between accepts, expected %0d", a1 - a0, WIDTH);
      end
      drain();
   endtask

   task automatic test_stall();
      int a;
      logic [3:0] pat;
      logic prev_stall;
      logic [1:0] prev;
      pat = 4'b1001;          // O_ready sequence 1,0,0,1 (bit 0 first)
      prev_stall = 1'b0;
      prev = 2'b00;
      bus.O_ready = 1'b1;
      send(4'd5, a);
      for (int i = 0; i < 24; i++) begin
         bus.O_ready = pat[i % 4];
         @(negedge CLK);
         if (prev_stall) begin
            tests++;
            if (bus.O_valid !== 1'b1 || {bus.O, bus.O_last} !== prev) begin
               fails++;
               $display("FAIL stall_hold: got vld=%b O/last=%b, expected 1 %b",
                        bus.O_valid, {bus.O, bus.O_last}, prev);
            end
         end
         prev_stall = bus.O_valid && !bus.O_ready;
         prev = {bus.O, bus.O_last};
         @(posedge CLK);
         #1;
      end
      bus.O_ready = 1'b1;
      drain();
   endtask

   task automatic test_clamp();
      int a;
      bus.O_ready = 1'b1;
      send(4'd12, a);
      tests++;
      if (bus.clamp !== 1'b1) begin
         fails++;
         $display("FAIL clamp_set: got %b, expected 1", bus.clamp);
      end
      drain();
      send(4'd2, a);
      drain();
      tests++;
      if (bus.clamp !== 1'b1) begin
         fails++;
         $display("FAIL clamp_sticky: got %b, expected 1", bus.clamp);
      end
   endtask

   task automatic test_reset_mid();
      int a;
      int t;
      bus.O_ready = 1'b1;
      send(4'd6, a);
      for (t = 0; t < 50 && q.size() > WIDTH - 3; t++) @(negedge CLK);
      @(posedge CLK);
      #2;
      ASYNCRESETN = 1'b0;
      #1;
      tests++;
      if (bus.O_valid !== 1'b0 || bus.I_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid: got O_valid=%b I_ready=%b, expected 0 1", bus.O_valid, bus.I_ready);
      end
      q.delete();
      repeat (2) @(posedge CLK);
      #2;
      ASYNCRESETN = 1'b1;
      @(posedge CLK);
      #1;
      tests++;
      if (bus.O_valid !== 1'b0 || bus.clamp !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: got O_valid=%b clamp=%b, expected 0 0", bus.O_valid, bus.clamp);
      end
      send(4'd1, a);
      drain();
   endtask

   task automatic test_sweep();
      int a;
      logic [WIDTH-1:0] w;
      bus.O_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         send(CW'(c), a);
         w = '0;
         for (int k = 0; k < WIDTH; k++) if (k < c) w[k] = 1'b1;
`ifdef POPCOUNT_UNARY_SER8_PAR_EN
         tests++;
         if (bus.O_par !== w) begin
            fails++;
            $display("FAIL par_word: count %0d got %h, expected %h", c, bus.O_par, w);
         end
`endif
      end
      drain();
      tests++;
      if (bus.clamp !== 1'b1) begin
         fails++;
         $display("FAIL sweep_clamp: got %b, expected 1", bus.clamp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_clamp();
      test_sweep();
      repeat (2) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
